mips_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit owning the HI/LO register pair for the MIPS core.
- Executes MULT, MULTU, DIV and DIVU over XLEN cycles and exposes HI/LO to the datapath for MFHI/MFLO.
- Accepts MTHI/MTLO writes.
- Sits beside the ALU; the controller issues start/op from decode and stalls the core on busy when it needs HI/LO.

---
 rtl/mips_muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MIPS multiply/divide unit owning HI/LO
//
// Purpose: executes MULT/MULTU (shift-add) and DIV/DIVU (restoring) over XLEN
// RUN cycles, plus MTHI/MTLO writes. Optional macro MULDIV_EARLY_OUT_EN lets a
// multiply leave RUN as soon as the remaining multiplier bits are all zero.
//
// Ports:
//   clk, rst_b             clock; asynchronous active-high reset
//   start, op              operation request (sampled in IDLE); 00 MULT,
//                          01 MULTU, 10 DIV, 11 DIVU
//   rs_data, rt_data       multiplicand/dividend, multiplier/divisor
//   flush                  abort in-flight operation, HI/LO untouched
//   mthi_en, mtlo_en       write wr_data to HI / LO (IDLE only)
//   wr_data                MTHI/MTLO data
//   busy, done, divzero    status; done is a one-cycle result pulse
//   hi, lo                 HI/LO registers
module mips_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            flush,
  input  logic            mthi_en,
  input  logic            mtlo_en,
  input  logic [XLEN-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic            divzero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   rs_q, rt_q;
  logic [XLEN-1:0]   mcand_q;    // multiplicand or divisor magnitude
  logic [XLEN:0]     work_hi_q;  // product upper half / partial remainder
  logic [XLEN-1:0]   work_lo_q;  // multiplier bits + product lower half / quotient
  logic              neg_quot_q, neg_rem_q, dz_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              is_div, is_signed, rt_zero, last_iter, early_done;
  logic [XLEN-1:0]   abs_rs, abs_rt;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_raw, prod_aln, prod_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign rt_zero   = (rt_q == '0);
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
  assign abs_rs    = (is_signed && rs_q[XLEN-1]) ? -rs_q : rs_q;
  assign abs_rt    = (is_signed && rt_q[XLEN-1]) ? -rt_q : rt_q;

  // Multiply step: add the multiplicand when the current multiplier bit is set,
  // then the whole {work_hi, work_lo} pair shifts right by one. work_hi's top
  // bit stays zero for multiplies, so the X+1-bit add cannot overflow.
  assign mul_sum   = work_hi_q + (work_lo_q[0] ? {1'b0, mcand_q} : '0);

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor only when it fits.
  assign div_shift = {work_hi_q[XLEN-1:0], work_lo_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand_q});
  assign div_diff  = div_shift - {1'b0, mcand_q};

  assign prod_raw  = {work_hi_q[XLEN-1:0], work_lo_q};

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [CNT_W-1:0] XLEN_C = CNT_W'(XLEN);
  logic [XLEN-1:0] mrem_q;  // multiplier bits not yet consumed
  // After k iterations with no multiplier bits left, the pair holds the full
  // product shifted left by the XLEN-k skipped positions.
  assign early_done = !is_div && ((mrem_q >> 1) == '0);
  assign prod_aln   = prod_raw >> (XLEN_C - cnt_q);
`else
  assign early_done = 1'b0;
  assign prod_aln   = prod_raw;
`endif

  assign prod_fix  = neg_quot_q ? -prod_aln : prod_aln;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (start) state_d = PREP;
      PREP:    state_d = (is_div && rt_zero) ? FIX : RUN;
      RUN:     if (last_iter || early_done) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      op_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      mcand_q    <= '0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      done       <= 1'b0;
      divzero    <= 1'b0;
      hi         <= '0;
      lo         <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      mrem_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (mthi_en) hi <= wr_data;
        if (mtlo_en) lo <= wr_data;
        if (start) begin
          op_q    <= op;
          rs_q    <= rs_data;
          rt_q    <= rt_data;
          divzero <= 1'b0;
        end
      end else if (!flush) begin
        case (state_q)
          PREP: begin
            neg_quot_q <= is_signed & (rs_q[XLEN-1] ^ rt_q[XLEN-1]);
            neg_rem_q  <= is_signed & rs_q[XLEN-1];
            dz_q       <= is_div & rt_zero;
            cnt_q      <= '0;
            work_hi_q  <= '0;
            if (is_div) begin
              mcand_q   <= abs_rt;
              work_lo_q <= abs_rs;
            end else begin
              mcand_q   <= abs_rs;
              work_lo_q <= abs_rt;
            end
`ifdef MULDIV_EARLY_OUT_EN
            mrem_q <= abs_rt;
`endif
          end
          RUN: begin
            cnt_q <= cnt_q + 1'b1;
            if (is_div) begin
              work_hi_q <= div_ge ? div_diff : div_shift;
              work_lo_q <= {work_lo_q[XLEN-2:0], div_ge};
            end else begin
              work_hi_q <= {1'b0, mul_sum[XLEN:1]};
              work_lo_q <= {mul_sum[0], work_lo_q[XLEN-1:1]};
            end
`ifdef MULDIV_EARLY_OUT_EN
            mrem_q <= mrem_q >> 1;
`endif
          end
          FIX: begin
            done <= 1'b1;
            if (dz_q) begin
              hi      <= rs_q;
              lo      <= '1;
              divzero <= 1'b1;
            end else if (is_div) begin
              lo <= neg_quot_q ? -work_lo_q : work_lo_q;
              hi <= neg_rem_q ? -work_hi_q[XLEN-1:0] : work_hi_q[XLEN-1:0];
            end else begin
              hi <= prod_fix[2*XLEN-1:XLEN];
              lo <= prod_fix[XLEN-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - self-checking bench for mips_muldiv_unit
module tb_mips_muldiv_unit;

  logic        clk, rst_b, start, flush, mthi_en, mtlo_en;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        busy, done, divzero;
  logic [31:0] hi, lo;

  int n_asserts = 0;
  int n_fail    = 0;

  mips_muldiv_unit dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .mthi_en(mthi_en), .mtlo_en(mtlo_en), .wr_data(wr_data),
    .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs, rt, exp_hi, exp_lo;
    logic        exp_dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from plain arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml, output logic md);
    logic [63:0] p;
    longint sa, sb;
    int ia, ib;
    md = 1'b0; mh = '0; ml = '0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ia = $signed(a); ib = $signed(b);
    case (o)
      2'b00: begin p = 64'(sa * sb); mh = p[63:32]; ml = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; mh = p[63:32]; ml = p[31:0]; end
      2'b10: begin
        if (b == 0) begin mh = a; ml = '1; md = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin mh = 0; ml = 32'h8000_0000; end
        else begin ml = 32'(ia / ib); mh = 32'(ia % ib); end
      end
      default: begin
        if (b == 0) begin mh = a; ml = '1; md = 1'b1; end
        else begin ml = a / b; mh = a % b; end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    int n;
    logic [31:0] m;
    if (o[1] && b == 0) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      m = (o == 2'b00 && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return n + 2;
    end
`endif
    n = 0; m = b;
    return 34;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("divzero_clear_on_start", 64'(divzero), 64'(0));
    busy_ok = busy;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin lat = k; break; end
      if (!busy) busy_ok = 1'b0;
    end
    if (lat < 0) chk("done_timeout", 64'(0), 64'(1));
    else         chk("busy_low_at_done", 64'(busy), 64'(0));
  endtask

  task automatic wr_regs(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    mthi_en = h; mtlo_en = l; wr_data = d;
    @(negedge clk);
    mthi_en = 1'b0; mtlo_en = 1'b0;
  endtask

  task automatic start_only(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t        vecs[9];
  int          lat;
  logic        bok, seen;
  logic [31:0] mh, ml;
  logic        md;
  logic [1:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    rst_b = 1'b1; start = 0; flush = 0; mthi_en = 0; mtlo_en = 0;
    op = 0; rs_data = 0; rt_data = 0; wr_data = 0;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};

    @(negedge clk);
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_divzero", 64'(divzero), 64'(0));
    rst_b = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, bok);
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
      chk($sformatf("vec%0d_divzero", i), 64'(divzero), 64'(vecs[i].exp_dz));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].rt)));
      chk($sformatf("vec%0d_busy", i), 64'(bok), 64'(1));
      if (vecs[i].exp_dz) begin
        repeat (3) @(negedge clk);
        chk("divzero_held", 64'(divzero), 64'(1));
      end
    end

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(0, 15));
        2:       rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, mh, ml, md);
      run_op(ro, ra, rb, lat, bok);
      chk($sformatf("rnd%0d_hi op%0d %h %h", n, ro, ra, rb), 64'(hi), 64'(mh));
      chk($sformatf("rnd%0d_lo", n), 64'(lo), 64'(ml));
      chk($sformatf("rnd%0d_divzero", n), 64'(divzero), 64'(md));
      chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(exp_lat(ro, rb)));
    end

    // MTHI/MTLO in IDLE, then MTHI while busy must be ignored.
    wr_regs(1'b1, 1'b1, 32'hA5A5_A5A5);
    chk("mt_both_hi", 64'(hi), 64'hA5A5_A5A5);
    chk("mt_both_lo", 64'(lo), 64'hA5A5_A5A5);
    wr_regs(1'b0, 1'b1, 32'h1234_5678);
    chk("mtlo_lo", 64'(lo), 64'h1234_5678);
    chk("mtlo_hi_kept", 64'(hi), 64'hA5A5_A5A5);
    start_only(2'b01, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    mthi_en = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    mthi_en = 1'b0;
    chk("mthi_busy_ignored", 64'(hi), 64'hA5A5_A5A5);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk); @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("mul3x5_done", 64'(seen), 64'(1));
    chk("mul3x5_hi", 64'(hi), 64'(0));
    chk("mul3x5_lo", 64'(lo), 64'h0000_000F);

    // Asynchronous reset mid-operation.
    wr_regs(1'b1, 1'b1, 32'h5555_AAAA);
    start_only(2'b01, 32'd2, 32'd2);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("rst_mid_hi", 64'(hi), 64'(0));
    chk("rst_mid_lo", 64'(lo), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_b = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rst_mid_no_done", 64'(seen), 64'(0));

    // Flush mid-operation keeps HI/LO and produces no done.
    wr_regs(1'b1, 1'b0, 32'h1111_1111);
    wr_regs(1'b0, 1'b1, 32'h2222_2222);
    start_only(2'b01, 32'd2, 32'd2);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(0));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("flush_no_done", 64'(seen), 64'(0));
    chk("flush_hi", 64'(hi), 64'h1111_1111);
    chk("flush_lo", 64'(lo), 64'h2222_2222);

    // Flush in IDLE has no effect.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'(0));
    chk("flush_idle_hi", 64'(hi), 64'h1111_1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
